// File: rtl/mul_fx_pkg.sv
// Shared FSM type and format constants for the mul_fx_seq fixed-point multiplier.
package mul_fx_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  // Wide enough for any supported WIDTH; callers cast down to their own width.
  localparam int CONST_W = 128;

  function automatic logic [CONST_W-1:0] round_const(input int frac);
    logic [CONST_W-1:0] r;
    if (frac > 0) begin
      r = 128'd1 << (frac - 1);
    end else begin
      r = 128'd0;
    end
    return r;
  endfunction

  function automatic logic [CONST_W-1:0] smax_const(input int width);
    return (128'd1 << (width - 1)) - 128'd1;
  endfunction

  // Two's-complement pattern of the most negative value; numerically equal to its magnitude.
  function automatic logic [CONST_W-1:0] smin_const(input int width);
    return 128'd1 << (width - 1);
  endfunction

  function automatic logic [CONST_W-1:0] umax_const(input int width);
    return (128'd1 << width) - 128'd1;
  endfunction

endpackage

// File: rtl/mul_fx_post.sv
// Combinational round / sign / saturate stage applied to the magnitude product.
// Saturation and overflow detection exist only when MUL_FX_SAT_EN is defined.
module mul_fx_post
  import mul_fx_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int FRAC   = 16,
  parameter int SIGNED = 1
) (
  input  logic [2*WIDTH-1:0] acc,
  input  logic               neg,
  output logic [WIDTH-1:0]   res,
  output logic               ovf
);

  localparam logic [2*WIDTH-1:0] RND = (2*WIDTH)'(round_const(FRAC));

  logic [2*WIDTH-1:0] sum_s;
  logic [WIDTH-1:0]   mag_lo_s;

  assign sum_s    = acc + RND;
  assign mag_lo_s = WIDTH'(sum_s >> FRAC);

`ifdef MUL_FX_SAT_EN
  localparam logic [2*WIDTH-1:0] LIM_POS = (SIGNED != 0) ? (2*WIDTH)'(smax_const(WIDTH))
                                                         : (2*WIDTH)'(umax_const(WIDTH));
  localparam logic [2*WIDTH-1:0] LIM_NEG = (2*WIDTH)'(smin_const(WIDTH));
  localparam logic [WIDTH-1:0]   SAT_MAX = (SIGNED != 0) ? WIDTH'(smax_const(WIDTH))
                                                         : WIDTH'(umax_const(WIDTH));
  localparam logic [WIDTH-1:0]   SAT_MIN = WIDTH'(smin_const(WIDTH));

  logic [2*WIDTH-1:0] mag_s;
  logic               neg_s;

  assign mag_s = sum_s >> FRAC;
  // A zero magnitude is always reported as positive.
  assign neg_s = (SIGNED != 0) && neg && (mag_s != '0);

  // Clamp against the limit of the result's own sign, otherwise apply the sign.
  always_comb begin
    res = mag_lo_s;
    ovf = 1'b0;
    if (neg_s) begin
      if (mag_s > LIM_NEG) begin
        ovf = 1'b1;
        res = SAT_MIN;
      end else begin
        ovf = 1'b0;
        res = -mag_lo_s;
      end
    end else begin
      if (mag_s > LIM_POS) begin
        ovf = 1'b1;
        res = SAT_MAX;
      end else begin
        ovf = 1'b0;
        res = mag_lo_s;
      end
    end
  end
`else
  assign res = ((SIGNED != 0) && neg) ? -mag_lo_s : mag_lo_s;
  assign ovf = 1'b0;
`endif

endmodule

// File: rtl/mul_fx_seq.sv
// Sequential radix-2 shift-add fixed-point multiplier with start/done handshake.
// Define MUL_FX_SAT_EN to clamp overflowing results and report ovf.
module mul_fx_seq
  import mul_fx_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int FRAC   = 16,
  parameter int SIGNED = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] ab,
  output logic             ovf
);

  localparam int               CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_t             state_r, state_nx_s;
  logic [2*WIDTH-1:0] mc_r, acc_r;
  logic [WIDTH-1:0]   mb_r, ab_r;
  logic [CNT_W-1:0]   cnt_r;
  logic               sign_r, ovf_r, done_r, busy_r;

  logic               a_neg_s, b_neg_s, post_ovf_s;
  logic [WIDTH-1:0]   a_mag_s, b_mag_s, post_ab_s;

  // Negating the most negative value yields 2^(WIDTH-1), which is exact as unsigned.
  assign a_neg_s = (SIGNED != 0) && a[WIDTH-1];
  assign b_neg_s = (SIGNED != 0) && b[WIDTH-1];
  assign a_mag_s = a_neg_s ? -a : a;
  assign b_mag_s = b_neg_s ? -b : b;

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) state_nx_s = RUN;
        else       state_nx_s = IDLE;
      end
      RUN: begin
        if (cnt_r == CNT_LAST) state_nx_s = FIN;
        else                   state_nx_s = RUN;
      end
      FIN:     state_nx_s = IDLE;
      default: state_nx_s = IDLE;
    endcase
  end

  // Operand capture, shift-add iteration and result/flag registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mc_r   <= '0;
      mb_r   <= '0;
      acc_r  <= '0;
      cnt_r  <= '0;
      sign_r <= 1'b0;
      ab_r   <= '0;
      ovf_r  <= 1'b0;
      done_r <= 1'b0;
      busy_r <= 1'b0;
    end else begin
      busy_r <= (state_nx_s != IDLE);
      done_r <= (state_r == FIN);
      case (state_r)
        IDLE: begin
          if (start) begin
            mc_r   <= {{WIDTH{1'b0}}, a_mag_s};
            mb_r   <= b_mag_s;
            acc_r  <= '0;
            cnt_r  <= '0;
            sign_r <= a_neg_s ^ b_neg_s;
          end
        end
        RUN: begin
          if (mb_r[0]) acc_r <= acc_r + mc_r;
          mc_r  <= {mc_r[2*WIDTH-2:0], 1'b0};
          mb_r  <= {1'b0, mb_r[WIDTH-1:1]};
          cnt_r <= cnt_r + CNT_W'(1);
        end
        FIN: begin
          ab_r  <= post_ab_s;
          ovf_r <= post_ovf_s;
        end
        default: ;
      endcase
    end
  end

  mul_fx_post #(
    .WIDTH  (WIDTH),
    .FRAC   (FRAC),
    .SIGNED (SIGNED)
  ) u_post (
    .acc (acc_r),
    .neg (sign_r),
    .res (post_ab_s),
    .ovf (post_ovf_s)
  );

  assign busy = busy_r;
  assign done = done_r;
  assign ab   = ab_r;
  assign ovf  = ovf_r;

endmodule

// File: tb/tb_mul_fx_seq.sv
// Directed-vector bench for mul_fx_seq: a signed Q16.16 instance and an unsigned one.
module tb_mul_fx_seq;

`ifdef MUL_FX_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0, start_u = 1'b0;
  logic [31:0] a = 32'd0, b = 32'd0, a_u = 32'd0, b_u = 32'd0;
  logic        busy, done, ovf, busy_u, done_u, ovf_u;
  logic [31:0] ab, ab_u;

  int nvec = 0;
  int nmis = 0;

  always #5 clk = ~clk;

  mul_fx_seq #(.WIDTH(32), .FRAC(16), .SIGNED(1)) u_dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .ab(ab), .ovf(ovf)
  );

  mul_fx_seq #(.WIDTH(32), .FRAC(16), .SIGNED(0)) u_dut_u (
    .clk(clk), .rst(rst), .start(start_u), .a(a_u), .b(b_u),
    .busy(busy_u), .done(done_u), .ab(ab_u), .ovf(ovf_u)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nmis++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Presents operands and a one-cycle start; returns at the falling edge after acceptance.
  task automatic start_op(input logic [31:0] ta, input logic [31:0] tb_, input bit uns);
    @(negedge clk);
    if (uns) begin a_u = ta; b_u = tb_; start_u = 1'b1; end
    else     begin a = ta;   b = tb_;   start = 1'b1;   end
    @(negedge clk);
    start = 1'b0;
    start_u = 1'b0;
  endtask

  task automatic wait_done(input bit uns, output int lat);
    lat = 0;
    while (((uns ? done_u : done) !== 1'b1) && lat < 60) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic run(input string tag, input logic [31:0] ta, input logic [31:0] tb_,
                     input logic [31:0] exp_ab, input logic exp_ovf, input bit uns);
    int lat;
    start_op(ta, tb_, uns);
    check({tag, "_busy"}, {31'd0, uns ? busy_u : busy}, 32'd1);
    wait_done(uns, lat);
    check({tag, "_lat"}, lat, 32'd33);
    check({tag, "_busyoff"}, {31'd0, uns ? busy_u : busy}, 32'd0);
    check({tag, "_ab"}, uns ? ab_u : ab, exp_ab);
    check({tag, "_ovf"}, {31'd0, uns ? ovf_u : ovf}, {31'd0, exp_ovf});
  endtask

  logic [31:0] bb_a [3] = '{32'h0001_8000, 32'hFFFE_0000, 32'h0000_0003};
  logic [31:0] bb_b [3] = '{32'h0002_0000, 32'h0000_8000, 32'h0000_8000};
  logic [31:0] bb_e [3] = '{32'h0003_0000, 32'hFFFF_0000, 32'h0000_0002};

  initial begin
    int lat;
    #12;
    check("rst_ab",   ab, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_ovf",  {31'd0, ovf}, 32'd0);
    @(negedge clk);
    rst = 1'b1;

    run("mul2x3",   32'h0002_0000, 32'h0003_0000, 32'h0006_0000, 1'b0, 1'b0);
    run("neg1x2p5", 32'hFFFF_0000, 32'h0002_8000, 32'hFFFD_8000, 1'b0, 1'b0);
    run("rnd_up",   32'h0000_0001, 32'h0000_8000, 32'h0000_0001, 1'b0, 1'b0);
    run("rnd_neg",  32'hFFFF_FFFF, 32'h0000_8000, 32'hFFFF_FFFF, 1'b0, 1'b0);
    run("rnd_dn",   32'h0000_0001, 32'h0000_7FFF, 32'h0000_0000, 1'b0, 1'b0);
    run("neg_zero", 32'hFFFF_FFFF, 32'h0000_7FFF, 32'h0000_0000, 1'b0, 1'b0);
    run("rnd_neg3", 32'hFFFF_FFFD, 32'h0000_8000, 32'hFFFF_FFFE, 1'b0, 1'b0);
    run("min_x1",   32'h8000_0000, 32'h0001_0000, 32'h8000_0000, 1'b0, 1'b0);
    run("ovf_pos",  32'h7FFF_0000, 32'h0002_0000, SAT ? 32'h7FFF_FFFF : 32'hFFFE_0000, SAT, 1'b0);
    run("ovf_mxm1", 32'h8000_0000, 32'hFFFF_0000, SAT ? 32'h7FFF_FFFF : 32'h8000_0000, SAT, 1'b0);
    run("ovf_neg",  32'h8000_0000, 32'h0002_0000, SAT ? 32'h8000_0000 : 32'h0000_0000, SAT, 1'b0);

    run("u_1x2p5",  32'h0001_0000, 32'h0002_8000, 32'h0002_8000, 1'b0, 1'b1);
    run("u_big",    32'hFFFF_0000, 32'h0001_0000, 32'hFFFF_0000, 1'b0, 1'b1);
    run("u_ovf",    32'h8000_0000, 32'h0002_0000, SAT ? 32'hFFFF_FFFF : 32'h0000_0000, SAT, 1'b1);

    // start pulsed at E5 while running must be ignored
    start_op(32'h0002_0000, 32'h0003_0000, 1'b0);
    repeat (4) @(negedge clk);
    a = 32'h7FFF_0000; b = 32'h0002_0000; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(1'b0, lat);
    check("ign_lat", lat, 32'd28);
    check("ign_ab", ab, 32'h0006_0000);

    // reset in the middle of a second operation
    start_op(32'h0003_0000, 32'h0003_0000, 1'b0);
    repeat (9) @(negedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    #1;
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_done", {31'd0, done}, 32'd0);
    check("mid_rst_ab", ab, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    run("after_rst", 32'h0003_0000, 32'h0003_0000, 32'h0009_0000, 1'b0, 1'b0);

    // start held high across three back-to-back operations
    @(negedge clk);
    a = bb_a[0]; b = bb_b[0]; start = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (i < 2) begin
        a = bb_a[i+1]; b = bb_b[i+1];
      end else begin
        start = 1'b0;
      end
      wait_done(1'b0, lat);
      check($sformatf("b2b%0d_lat", i), lat, 32'd33);
      check($sformatf("b2b%0d_ab", i), ab, bb_e[i]);
    end

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
